// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin front end for a shared ripple adder/subtractor
// Operands and result are registered; one operation is in flight at a time.

module adder_subtractor #(
   parameter int w = 8
) (
   input  logic [w-1:0] a,
   input  logic [w-1:0] b,
   input  logic         sub,
   output logic [w-1:0] z
);
   logic [w:0] c;

   // Subtraction as a + ~b + 1: the invert rides on b, the +1 enters as carry-in.
   assign c[0] = sub;

   for (genvar i = 0; i < w; i++) begin : g_fac
      logic bx;
      assign bx       = b[i] ^ sub;
      assign z[i]     = a[i] ^ bx ^ c[i];
      assign c[i + 1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
   end
endmodule

module addsub_arbiter #(
   parameter int w = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*w-1:0] req_x,
   input  logic [2*w-1:0] req_y,
   input  logic [1:0]     req_sub,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [w-1:0]   rsp_z,
   output logic           rsp_ovf
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           prio;
   logic           grant;
   logic           accept;
   logic [w-1:0]   x_r;
   logic [w-1:0]   y_r;
   logic           sub_r;
   logic           id_r;
   logic [w-1:0]   z;
   logic           ovf;

   // Priority only matters when both ask; otherwise the lone requester wins.
   assign grant  = (req_valid == 2'b11) ? prio : req_valid[1];
   // Gated by rst so ready reads 0 while reset is held, even though state is IDLE.
   assign accept = (state == IDLE) && req_valid[grant] && !rst;

   adder_subtractor #(.w(w)) u_alu (
      .a   (x_r),
      .b   (y_r),
      .sub (sub_r),
      .z   (z)
   );

   assign ovf = sub_r ? ((x_r[w-1] != y_r[w-1]) && (z[w-1] != x_r[w-1]))
                      : ((x_r[w-1] == y_r[w-1]) && (z[w-1] != x_r[w-1]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 1'b0;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end
      if (state == RESP) begin
         rsp_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r     <= '0;
         y_r     <= '0;
         sub_r   <= 1'b0;
         id_r    <= 1'b0;
         prio    <= 1'b0;
         rsp_z   <= '0;
         rsp_ovf <= 1'b0;
      end else begin
         if (accept) begin
            x_r   <= grant ? req_x[2*w-1:w] : req_x[w-1:0];
            y_r   <= grant ? req_y[2*w-1:w] : req_y[w-1:0];
            sub_r <= req_sub[grant];
            id_r  <= grant;
            prio  <= ~grant;
         end
         if (state == EXEC) begin
            rsp_z   <= z;
            rsp_ovf <= ovf;
         end
      end
   end

   assign rsp_id = id_r;
endmodule
